// File: rtl/img_slv_arbiter_if.sv
// Bus bundle between the two pixel slaves, the arbiter and the core.
// slave: the arbiter's view; master: the environment's view.
interface img_slv_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COLOR_SIZE = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [1:0]            slv0_mode;
  logic [COLOR_SIZE-1:0] slv0_proc_val;
  logic                  slv0_data_valid;
  logic [DATA_WIDTH-1:0] slv0_data;
  logic                  slv0_last;
  logic                  slv0_rdy;

  logic [1:0]            slv1_mode;
  logic [COLOR_SIZE-1:0] slv1_proc_val;
  logic                  slv1_data_valid;
  logic [DATA_WIDTH-1:0] slv1_data;
  logic                  slv1_last;
  logic                  slv1_rdy;

  logic [1:0]            proc_mode;
  logic [COLOR_SIZE-1:0] proc_val;
  logic                  proc_data_valid;
  logic [DATA_WIDTH-1:0] proc_data;
  logic                  proc_last;
  logic                  proc_rdy;
  logic                  proc_cmplt;

  logic [1:0]            grant;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  timeout_err;

  modport slave (
    input  slv0_mode, slv0_proc_val,
    input  slv0_data_valid, slv0_data,
    input  slv0_last,
    output slv0_rdy,
    input  slv1_mode, slv1_proc_val,
    input  slv1_data_valid, slv1_data,
    input  slv1_last,
    output slv1_rdy,
    output proc_mode, proc_val,
    output proc_data_valid, proc_data,
    output proc_last,
    input  proc_rdy, proc_cmplt,
    output grant, beat_cnt, timeout_err
  );

  modport master (
    output slv0_mode, slv0_proc_val,
    output slv0_data_valid, slv0_data,
    output slv0_last,
    input  slv0_rdy,
    output slv1_mode, slv1_proc_val,
    output slv1_data_valid, slv1_data,
    output slv1_last,
    input  slv1_rdy,
    input  proc_mode, proc_val,
    input  proc_data_valid, proc_data,
    input  proc_last,
    output proc_rdy, proc_cmplt,
    input  grant, beat_cnt, timeout_err
  );
endinterface

// File: rtl/img_slv_arbiter.sv
// Round-robin burst arbiter sharing the pixel datapath between two slaves.
// Holds ownership until last, then waits for core completion or watchdog.
module img_slv_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int COLOR_SIZE = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  img_slv_arbiter_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_CMPLT
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [1:0]            mode_q, mode_d;
  logic [COLOR_SIZE-1:0] val_q, val_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  terr_q, terr_d;

  logic                  pdv, pl, r0, r1;
  logic [DATA_WIDTH-1:0] pd;
  logic                  beat, pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      mode_q  <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  // Owner pass-through; grant is only nonzero while in BURST.
  always_comb begin
    pdv = 1'b0;
    pd  = '0;
    pl  = 1'b0;
    r0  = 1'b0;
    r1  = 1'b0;
    unique case (1'b1)
      grant_q[0]: begin
        pdv = bus.slv0_data_valid;
        pd  = bus.slv0_data;
        pl  = bus.slv0_last;
        r0  = bus.proc_rdy;
      end
      grant_q[1]: begin
        pdv = bus.slv1_data_valid;
        pd  = bus.slv1_data;
        pl  = bus.slv1_last;
        r1  = bus.proc_rdy;
      end
      default: ;
    endcase
  end

  assign beat = pdv & bus.proc_rdy;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    mode_d  = mode_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    terr_d  = 1'b0;
    pick1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.slv0_data_valid | bus.slv1_data_valid) begin
          pick1 = bus.slv1_data_valid
                & (~bus.slv0_data_valid | ~last_q);
          grant_d = pick1 ? 2'b10 : 2'b01;
          mode_d  = pick1 ? bus.slv1_mode
                          : bus.slv0_mode;
          val_d   = pick1 ? bus.slv1_proc_val
                          : bus.slv0_proc_val;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          if (cnt_q != '1)
            cnt_d = cnt_q + CNT_WIDTH'(1);
          if (pl) begin
            state_d = WAIT_CMPLT;
            last_d  = grant_q[1];
            grant_d = 2'b00;
            wd_d    = '0;
          end
        end
      end
      WAIT_CMPLT: begin
        // Completion beats a same-cycle watchdog expiry.
        if (bus.proc_cmplt) begin
          state_d = IDLE;
        end else if (wd_q == WD_MAX) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.slv0_rdy        = r0;
  assign bus.slv1_rdy        = r1;
  assign bus.proc_data_valid = pdv;
  assign bus.proc_data       = pd;
  assign bus.proc_last       = pl;
  assign bus.proc_mode       = mode_q;
  assign bus.proc_val        = val_q;
  assign bus.grant           = grant_q;
  assign bus.beat_cnt        = cnt_q;
  assign bus.timeout_err     = terr_q;
endmodule

// File: tb/tb_img_slv_arbiter.sv
// Directed bench for img_slv_arbiter: cycle vector table
// plus hand sequences for reset, round-robin and watchdog.
module tb_img_slv_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  img_slv_arbiter_if #(
    .DATA_WIDTH(32),
    .COLOR_SIZE(8),
    .CNT_WIDTH (16)
  ) bus ();

  img_slv_arbiter #(
    .DATA_WIDTH(32),
    .COLOR_SIZE(8),
    .TIMEOUT   (8),
    .CNT_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic        l0;
    logic [1:0]  m0;
    logic        v1;
    logic [31:0] d1;
    logic        l1;
    logic [1:0]  m1;
    logic        rdy;
    logic        cm;
    logic [1:0]  gnt;
    logic        pdv;
    logic [31:0] pd;
    logic        pl;
    logic        r0;
    logic        r1;
    logic [1:0]  pm;
    logic [7:0]  pv;
    logic [15:0] bc;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    input logic v0, input logic [31:0] d0,
    input logic l0, input logic [1:0] m0,
    input logic v1, input logic [31:0] d1,
    input logic l1, input logic [1:0] m1,
    input logic rdy, input logic cm,
    input logic [1:0] gnt, input logic pdv,
    input logic [31:0] pd, input logic pl,
    input logic r0, input logic r1,
    input logic [1:0] pm, input logic [7:0] pv,
    input logic [15:0] bc
  );
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.m0 = m0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1; v.m1 = m1;
    v.rdy = rdy; v.cm = cm;
    v.gnt = gnt; v.pdv = pdv; v.pd = pd;
    v.pl = pl; v.r0 = r0; v.r1 = r1;
    v.pm = pm; v.pv = pv; v.bc = bc;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  logic [1:0] rr_exp [4];
  logic [1:0] g;
  int n;

  initial begin
    rst = 1'b1;
    bus.slv0_mode = 2'd0;
    bus.slv0_proc_val = 8'h40;
    bus.slv0_data_valid = 1'b1;
    bus.slv0_data = 32'h0;
    bus.slv0_last = 1'b0;
    bus.slv1_mode = 2'd0;
    bus.slv1_proc_val = 8'h77;
    bus.slv1_data_valid = 1'b0;
    bus.slv1_data = 32'h0;
    bus.slv1_last = 1'b0;
    bus.proc_rdy = 1'b0;
    bus.proc_cmplt = 1'b0;

    // reset held 2 cycles with slv0 requesting
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_pdv", 32'(bus.proc_data_valid), 32'h0);
    chk("rst_rdy0", 32'(bus.slv0_rdy), 32'h0);
    chk("rst_mode", 32'(bus.proc_mode), 32'h0);
    chk("rst_val", 32'(bus.proc_val), 32'h0);
    chk("rst_bc", 32'(bus.beat_cnt), 32'h0);
    chk("rst_terr", 32'(bus.timeout_err), 32'h0);
    rst = 1'b0;
    step();
    chk("rst_rel_grant", 32'(bus.grant), 32'h1);

    rst = 1'b1;
    bus.slv0_data_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    // v0 d0 l0 m0 | v1 d1 l1 m1 | rdy cm ||
    // gnt pdv pd pl r0 r1 pm pv bc
    tbl[0]  = mk(1,32'hA0,0,2, 0,0,0,0, 1,0,
                 0,0,0,0,0,0, 0,8'h00,0);
    tbl[1]  = mk(1,32'hA0,0,2, 0,0,0,0, 1,0,
                 1,1,32'hA0,0,1,0, 2,8'h40,0);
    tbl[2]  = mk(1,32'hA1,0,2, 0,0,0,0, 1,0,
                 1,1,32'hA1,0,1,0, 2,8'h40,1);
    tbl[3]  = mk(1,32'hA2,0,2, 0,0,0,0, 1,0,
                 1,1,32'hA2,0,1,0, 2,8'h40,2);
    tbl[4]  = mk(1,32'hA3,1,2, 0,0,0,0, 1,0,
                 1,1,32'hA3,1,1,0, 2,8'h40,3);
    tbl[5]  = mk(0,0,0,2, 0,0,0,0, 1,1,
                 0,0,0,0,0,0, 2,8'h40,4);
    tbl[6]  = mk(0,0,0,2, 1,32'hB0,0,1, 0,0,
                 0,0,0,0,0,0, 2,8'h40,4);
    tbl[7]  = mk(0,0,0,2, 1,32'hB0,0,3, 1,0,
                 2,1,32'hB0,0,0,1, 1,8'h77,0);
    tbl[8]  = mk(0,0,0,2, 1,32'hB1,0,3, 0,0,
                 2,1,32'hB1,0,0,0, 1,8'h77,1);
    tbl[9]  = mk(0,0,0,2, 1,32'hB1,0,3, 1,0,
                 2,1,32'hB1,0,0,1, 1,8'h77,1);
    tbl[10] = mk(0,0,0,2, 1,32'hB2,1,3, 0,0,
                 2,1,32'hB2,1,0,0, 1,8'h77,2);
    tbl[11] = mk(0,0,0,2, 1,32'hB2,1,3, 1,0,
                 2,1,32'hB2,1,0,1, 1,8'h77,2);
    tbl[12] = mk(1,32'hC0,1,2, 0,0,0,0, 1,0,
                 0,0,0,0,0,0, 1,8'h77,3);
    tbl[13] = mk(1,32'hC0,1,2, 0,0,0,0, 1,1,
                 0,0,0,0,0,0, 1,8'h77,3);
    tbl[14] = mk(1,32'hC0,1,2, 0,0,0,0, 1,0,
                 0,0,0,0,0,0, 1,8'h77,3);
    tbl[15] = mk(1,32'hC0,1,2, 0,0,0,0, 1,0,
                 1,1,32'hC0,1,1,0, 2,8'h40,0);
    tbl[16] = mk(0,0,0,2, 0,0,0,0, 1,1,
                 0,0,0,0,0,0, 2,8'h40,1);

    for (int i = 0; i < 17; i++) begin
      bus.slv0_data_valid = tbl[i].v0;
      bus.slv0_data = tbl[i].d0;
      bus.slv0_last = tbl[i].l0;
      bus.slv0_mode = tbl[i].m0;
      bus.slv1_data_valid = tbl[i].v1;
      bus.slv1_data = tbl[i].d1;
      bus.slv1_last = tbl[i].l1;
      bus.slv1_mode = tbl[i].m1;
      bus.proc_rdy = tbl[i].rdy;
      bus.proc_cmplt = tbl[i].cm;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i),
          32'(bus.grant), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_pdv", i),
          32'(bus.proc_data_valid), 32'(tbl[i].pdv));
      chk($sformatf("v%0d_pd", i),
          bus.proc_data, tbl[i].pd);
      chk($sformatf("v%0d_pl", i),
          32'(bus.proc_last), 32'(tbl[i].pl));
      chk($sformatf("v%0d_rdy0", i),
          32'(bus.slv0_rdy), 32'(tbl[i].r0));
      chk($sformatf("v%0d_rdy1", i),
          32'(bus.slv1_rdy), 32'(tbl[i].r1));
      chk($sformatf("v%0d_mode", i),
          32'(bus.proc_mode), 32'(tbl[i].pm));
      chk($sformatf("v%0d_val", i),
          32'(bus.proc_val), 32'(tbl[i].pv));
      chk($sformatf("v%0d_bc", i),
          32'(bus.beat_cnt), 32'(tbl[i].bc));
      chk($sformatf("v%0d_terr", i),
          32'(bus.timeout_err), 32'h0);
      step();
    end
    bus.proc_cmplt = 1'b0;

    // round-robin with both slaves requesting, 2-word bursts
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;
    rr_exp[3] = 2'b10;
    bus.slv0_data_valid = 1'b1;
    bus.slv1_data_valid = 1'b1;
    bus.slv0_last = 1'b0;
    bus.slv1_last = 1'b0;
    bus.proc_rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (bus.grant == 2'b00 && n < 20) begin
        step();
        n++;
      end
      g = bus.grant;
      chk($sformatf("rr%0d_grant", b),
          32'(g), 32'(rr_exp[b]));
      chk($sformatf("rr%0d_nonown_rdy_a", b),
          32'(rr_exp[b][0] ? bus.slv1_rdy
                           : bus.slv0_rdy), 32'h0);
      step();
      bus.slv0_last = 1'b1;
      bus.slv1_last = 1'b1;
      #1;
      chk($sformatf("rr%0d_grant_hold", b),
          32'(bus.grant), 32'(rr_exp[b]));
      chk($sformatf("rr%0d_nonown_rdy_b", b),
          32'(rr_exp[b][0] ? bus.slv1_rdy
                           : bus.slv0_rdy), 32'h0);
      chk($sformatf("rr%0d_last", b),
          32'(bus.proc_last), 32'h1);
      step();
      bus.slv0_last = 1'b0;
      bus.slv1_last = 1'b0;
      chk($sformatf("rr%0d_wait_grant", b),
          32'(bus.grant), 32'h0);
      chk($sformatf("rr%0d_bc", b),
          32'(bus.beat_cnt), 32'h2);
      step();
      step();
      bus.proc_cmplt = 1'b1;
      step();
      bus.proc_cmplt = 1'b0;
    end
    bus.slv0_data_valid = 1'b0;
    bus.slv1_data_valid = 1'b0;

    // watchdog: single-word slv0 burst, no completion
    bus.slv0_data_valid = 1'b1;
    bus.slv0_last = 1'b1;
    bus.slv0_data = 32'hD0;
    step();
    chk("wd_grant0", 32'(bus.grant), 32'h1);
    step();
    bus.slv0_data_valid = 1'b0;
    bus.slv0_last = 1'b0;
    bus.slv1_data_valid = 1'b1;
    bus.slv1_last = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("wd_terr_c%0d", c),
          32'(bus.timeout_err), 32'(c == 8));
    end
    chk("wd_grant_idle", 32'(bus.grant), 32'h0);
    step();
    chk("wd_terr_after", 32'(bus.timeout_err), 32'h0);
    chk("wd_next_grant", 32'(bus.grant), 32'h2);

    // completion on the last watchdog cycle wins
    step();
    bus.slv1_data_valid = 1'b0;
    bus.slv1_last = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("cm_terr_c%0d", c),
          32'(bus.timeout_err), 32'h0);
    end
    bus.proc_cmplt = 1'b1;
    step();
    bus.proc_cmplt = 1'b0;
    chk("cm_terr_c8", 32'(bus.timeout_err), 32'h0);
    step();
    chk("cm_terr_c9", 32'(bus.timeout_err), 32'h0);
    chk("cm_grant", 32'(bus.grant), 32'h0);

    // make slv0 the last owner, then reset mid slv1 burst
    bus.slv0_data_valid = 1'b1;
    bus.slv0_last = 1'b1;
    step();
    step();
    bus.slv0_last = 1'b0;
    bus.slv1_data_valid = 1'b1;
    bus.slv1_last = 1'b0;
    bus.slv1_data = 32'h501;
    bus.proc_cmplt = 1'b1;
    step();
    bus.proc_cmplt = 1'b0;
    step();
    chk("mr_grant", 32'(bus.grant), 32'h2);
    step();
    bus.slv1_data = 32'h502;
    step();
    chk("mr_bc2", 32'(bus.beat_cnt), 32'h2);
    rst = 1'b1;
    step();
    chk("mr_rst_grant", 32'(bus.grant), 32'h0);
    chk("mr_rst_pdv", 32'(bus.proc_data_valid), 32'h0);
    chk("mr_rst_bc", 32'(bus.beat_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("mr_tie_grant", 32'(bus.grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
